elevator_scan_controller: RTL and testbench

//  Parametrised elevator controller: queues floor calls in a pending bitmask and serves

---
 rtl/elevator_pkg.sv | 40 ++++
 rtl/elevator_tick_timer.sv | 28 ++
 rtl/elevator_scan_controller.sv | 178 +++++++++++++++++
 tb/tb_elevator_scan_controller.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator SCAN controller: state encodings,
// travel-direction constants and pending-call search helpers.
package elevator_pkg;

    localparam int unsigned MAX_FLOORS = 16;

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_MOVING_UP   = 2'd1;
    localparam logic [1:0] S_MOVING_DOWN = 2'd2;
    localparam logic [1:0] S_DOOR_OPEN   = 2'd3;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // pend is the pending mask zero-extended to MAX_FLOORS bits
    function automatic logic any_call_above(input logic [MAX_FLOORS-1:0] pend,
                                            input int unsigned f);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < MAX_FLOORS; i++) begin
            if ((i > f) && pend[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    function automatic logic any_call_below(input logic [MAX_FLOORS-1:0] pend,
                                            input int unsigned f);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < MAX_FLOORS; i++) begin
            if ((i < f) && pend[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/elevator_tick_timer.sv
// Free-running tick counter with synchronous load; tc flags the cycle on
// which the count equals the supplied terminal value.
module elevator_tick_timer #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] terminal,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == terminal);

endmodule

// File: rtl/elevator_scan_controller.sv
// Elevator controller serving queued floor calls in SCAN order, with
// per-floor travel delay and a restartable door dwell timer.
module elevator_scan_controller
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS   = 10,
    parameter int unsigned FLOOR_W      = 4,
    parameter int unsigned TRAVEL_TICKS = 16,
    parameter int unsigned DOOR_TICKS   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    output logic                  req_ready,
    output logic                  req_err,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open
);

    localparam int unsigned TICK_MAX = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int unsigned TIMER_W  = $clog2(TICK_MAX) + 1;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  dir;
    logic                  dir_next;
    logic [FLOOR_W-1:0]    floor_next;
    logic [FLOOR_W-1:0]    floor_up;
    logic [FLOOR_W-1:0]    floor_down;
    logic [NUM_FLOORS-1:0] set_mask;
    logic [NUM_FLOORS-1:0] clr_mask;
    logic [MAX_FLOORS-1:0] pend_ext;
    logic                  req_take;
    logic                  req_bad;
    logic                  door_restart;
    logic                  timer_load;
    logic                  timer_tc;
    logic [TIMER_W-1:0]    timer_terminal;

    function automatic logic pend_at(input logic [NUM_FLOORS-1:0] p,
                                     input logic [FLOOR_W-1:0] f);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (f == FLOOR_W'(i)) begin
                hit = p[i];
            end
        end
        return hit;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (f == FLOOR_W'(i)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    assign req_ready = reset;
    assign req_take  = req_valid & req_ready;
    assign req_bad   = req_take & (32'(req_floor) >= NUM_FLOORS);

    // A call for the floor the door is already open at only extends the dwell
    assign door_restart = req_take & ~req_bad & (state == S_DOOR_OPEN) &
                          (req_floor == current_floor);

    always_comb begin
        set_mask = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            set_mask[i] = req_take & ~req_bad & ~door_restart & (req_floor == FLOOR_W'(i));
        end
    end

    assign pend_ext   = MAX_FLOORS'(pending);
    assign floor_up   = (32'(current_floor) >= NUM_FLOORS - 1) ? current_floor
                                                               : current_floor + FLOOR_W'(1);
    assign floor_down = (current_floor == '0) ? current_floor : current_floor - FLOOR_W'(1);

    assign timer_terminal = (state == S_DOOR_OPEN) ? TIMER_W'(DOOR_TICKS - 1)
                                                   : TIMER_W'(TRAVEL_TICKS - 1);

    always_comb begin
        state_next = state;
        dir_next   = dir;
        floor_next = current_floor;
        clr_mask   = '0;
        timer_load = 1'b0;
        case (state)
            S_IDLE: begin
                timer_load = 1'b1;
                if (pend_at(pending, current_floor)) begin
                    state_next = S_DOOR_OPEN;
                    clr_mask   = floor_mask(current_floor);
                end else if (any_call_above(pend_ext, 32'(current_floor)) &&
                             ((dir == DIR_UP) || !any_call_below(pend_ext, 32'(current_floor)))) begin
                    state_next = S_MOVING_UP;
                    dir_next   = DIR_UP;
                end else if (any_call_below(pend_ext, 32'(current_floor))) begin
                    state_next = S_MOVING_DOWN;
                    dir_next   = DIR_DOWN;
                end
            end
            S_MOVING_UP: begin
                if (timer_tc) begin
                    floor_next = floor_up;
                    timer_load = 1'b1;
                    if (pend_at(pending, floor_up)) begin
                        state_next = S_DOOR_OPEN;
                        clr_mask   = floor_mask(floor_up);
                    end else if (!any_call_above(pend_ext, 32'(floor_up))) begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_MOVING_DOWN: begin
                if (timer_tc) begin
                    floor_next = floor_down;
                    timer_load = 1'b1;
                    if (pend_at(pending, floor_down)) begin
                        state_next = S_DOOR_OPEN;
                        clr_mask   = floor_mask(floor_down);
                    end else if (!any_call_below(pend_ext, 32'(floor_down))) begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                if (door_restart) begin
                    timer_load = 1'b1;
                end else if (timer_tc) begin
                    state_next = S_IDLE;
                    timer_load = 1'b1;
                end
            end
        endcase
    end

    elevator_tick_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val ('0),
        .terminal (timer_terminal),
        .tc       (timer_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            dir           <= DIR_UP;
            current_floor <= '0;
            pending       <= '0;
            req_err       <= 1'b0;
        end else begin
            state         <= state_next;
            dir           <= dir_next;
            current_floor <= floor_next;
            // set after clear: a new call beats a same-cycle service clear
            pending       <= (pending & ~clr_mask) | set_mask;
            req_err       <= req_bad;
        end
    end

    assign moving_up   = (state == S_MOVING_UP);
    assign moving_down = (state == S_MOVING_DOWN);
    assign door_open   = (state == S_DOOR_OPEN);

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Scoreboard bench: stimulus queues hand-derived output snapshots, a monitor
// pops one whenever the observable outputs change and checks value and spacing.
module tb_elevator_scan_controller;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic [3:0] req_floor;
    logic       req_ready;
    logic       req_err;
    logic [3:0] current_floor;
    logic [9:0] pending;
    logic       moving_up;
    logic       moving_down;
    logic       door_open;

    typedef struct packed {
        logic [3:0] floor;
        logic       up;
        logic       down;
        logic       door;
        logic [9:0] pend;
        logic       err;
    } snap_t;

    typedef struct {
        string name;
        snap_t s;
        int    delta;
    } ev_t;

    ev_t expq[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    bit  mon_en  = 1'b0;

    elevator_scan_controller #(
        .NUM_FLOORS   (10),
        .FLOOR_W      (4),
        .TRAVEL_TICKS (4),
        .DOOR_TICKS   (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_floor     (req_floor),
        .req_ready     (req_ready),
        .req_err       (req_err),
        .current_floor (current_floor),
        .pending       (pending),
        .moving_up     (moving_up),
        .moving_down   (moving_down),
        .door_open     (door_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ev(input string name, input int fl, input bit u, input bit d,
                      input bit o, input int p, input bit er, input int dl);
        ev_t e;
        e.name    = name;
        e.s.floor = 4'(fl);
        e.s.up    = u;
        e.s.down  = d;
        e.s.door  = o;
        e.s.pend  = 10'(p);
        e.s.err   = er;
        e.delta   = dl;
        expq.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic call(input int f);
        req_valid = 1'b1;
        req_floor = 4'(f);
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        req_floor = 4'd0;
    endtask

    task automatic check(input string name, input int got, input int expv);
        n_tests++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    task automatic drain(input int bound);
        int k;
        k = 0;
        while (expq.size() != 0 && k < bound) begin
            tick(1);
            k++;
        end
        if (expq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d events still outstanding, next %s",
                     expq.size(), expq[0].name);
            expq.delete();
        end
        tick(3);
    endtask

    // Monitor: one scoreboard comparison per change of the observable outputs
    initial begin
        snap_t prev;
        snap_t cur;
        ev_t   e;
        int    cnt;
        prev = '0;
        cnt  = 0;
        forever begin
            @(negedge clk);
            cur.floor = current_floor;
            cur.up    = moving_up;
            cur.down  = moving_down;
            cur.door  = door_open;
            cur.pend  = pending;
            cur.err   = req_err;
            if (!mon_en) begin
                prev = cur;
                cnt  = 0;
            end else begin
                cnt++;
                if (cur != prev) begin
                    n_tests++;
                    if (expq.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_event: got floor=%0d up=%0b down=%0b door=%0b pend=%03h err=%0b after %0d cycles, expected no change",
                                 cur.floor, cur.up, cur.down, cur.door, cur.pend, cur.err, cnt);
                    end else begin
                        e = expq.pop_front();
                        if (cur != e.s || (e.delta >= 0 && cnt != e.delta)) begin
                            n_fail++;
                            $display("FAIL %s: got floor=%0d up=%0b down=%0b door=%0b pend=%03h err=%0b after %0d cycles, expected floor=%0d up=%0b down=%0b door=%0b pend=%03h err=%0b after %0d cycles",
                                     e.name, cur.floor, cur.up, cur.down, cur.door, cur.pend, cur.err, cnt,
                                     e.s.floor, e.s.up, e.s.down, e.s.door, e.s.pend, e.s.err, e.delta);
                        end
                    end
                    prev = cur;
                    cnt  = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_floor = 4'd0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", 32'(req_ready), 0);
        check("rst_floor", 32'(current_floor), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_state", 32'({moving_up, moving_down, door_open, req_err}), 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("ready_after_release", 32'(req_ready), 1);
        tick(1);
        mon_en = 1'b1;
        tick(2);

        // 1: floor 0 -> 3
        ev("t1_call3",      0, 0, 0, 0, 'h008, 0, -1);
        ev("t1_go_up",      0, 1, 0, 0, 'h008, 0, 1);
        ev("t1_f1",         1, 1, 0, 0, 'h008, 0, 4);
        ev("t1_f2",         2, 1, 0, 0, 'h008, 0, 4);
        ev("t1_f3_door",    3, 0, 0, 1, 'h000, 0, 4);
        ev("t1_door_close", 3, 0, 0, 0, 'h000, 0, 3);
        call(3);
        drain(100);

        // 2: heading for 8, calls 2 and 7 placed while between 5 and 6
        ev("t2_call8",      3, 0, 0, 0, 'h100, 0, -1);
        ev("t2_go_up",      3, 1, 0, 0, 'h100, 0, 1);
        ev("t2_f4",         4, 1, 0, 0, 'h100, 0, 4);
        ev("t2_f5",         5, 1, 0, 0, 'h100, 0, 4);
        ev("t2_call2",      5, 1, 0, 0, 'h104, 0, 1);
        ev("t2_call7",      5, 1, 0, 0, 'h184, 0, 1);
        ev("t2_f6",         6, 1, 0, 0, 'h184, 0, 2);
        ev("t2_f7_door",    7, 0, 0, 1, 'h104, 0, 4);
        ev("t2_f7_close",   7, 0, 0, 0, 'h104, 0, 3);
        ev("t2_go_up8",     7, 1, 0, 0, 'h104, 0, 1);
        ev("t2_f8_door",    8, 0, 0, 1, 'h004, 0, 4);
        ev("t2_f8_close",   8, 0, 0, 0, 'h004, 0, 3);
        ev("t2_reverse",    8, 0, 1, 0, 'h004, 0, 1);
        ev("t2_f7_pass",    7, 0, 1, 0, 'h004, 0, 4);
        ev("t2_f6_pass",    6, 0, 1, 0, 'h004, 0, 4);
        ev("t2_f5_pass",    5, 0, 1, 0, 'h004, 0, 4);
        ev("t2_f4_pass",    4, 0, 1, 0, 'h004, 0, 4);
        ev("t2_f3_pass",    3, 0, 1, 0, 'h004, 0, 4);
        ev("t2_f2_door",    2, 0, 0, 1, 'h000, 0, 4);
        ev("t2_f2_close",   2, 0, 0, 0, 'h000, 0, 3);
        call(8);
        tick(9);
        call(2);
        call(7);
        drain(200);

        // 3: park at 5 travelling down, then pending {3,7} with dir DOWN
        ev("t3_call6",      2, 0, 0, 0, 'h040, 0, -1);
        ev("t3_go_up",      2, 1, 0, 0, 'h040, 0, 1);
        ev("t3_f3",         3, 1, 0, 0, 'h040, 0, 4);
        ev("t3_f4",         4, 1, 0, 0, 'h040, 0, 4);
        ev("t3_f5",         5, 1, 0, 0, 'h040, 0, 4);
        ev("t3_f6_door",    6, 0, 0, 1, 'h000, 0, 4);
        ev("t3_f6_close",   6, 0, 0, 0, 'h000, 0, 3);
        call(6);
        drain(100);
        ev("t3_call5",      6, 0, 0, 0, 'h020, 0, -1);
        ev("t3_go_down",    6, 0, 1, 0, 'h020, 0, 1);
        ev("t3_f5_door",    5, 0, 0, 1, 'h000, 0, 4);
        ev("t3_call3",      5, 0, 0, 1, 'h008, 0, 1);
        ev("t3_call7",      5, 0, 0, 1, 'h088, 0, 1);
        ev("t3_f5_close",   5, 0, 0, 0, 'h088, 0, 1);
        ev("t3_down_first", 5, 0, 1, 0, 'h088, 0, 1);
        ev("t3_f4",         4, 0, 1, 0, 'h088, 0, 4);
        ev("t3_f3_door",    3, 0, 0, 1, 'h080, 0, 4);
        ev("t3_f3_close",   3, 0, 0, 0, 'h080, 0, 3);
        ev("t3_then_up",    3, 1, 0, 0, 'h080, 0, 1);
        ev("t3_f4_up",      4, 1, 0, 0, 'h080, 0, 4);
        ev("t3_f5_up",      5, 1, 0, 0, 'h080, 0, 4);
        ev("t3_f6_up",      6, 1, 0, 0, 'h080, 0, 4);
        ev("t3_f7_door",    7, 0, 0, 1, 'h000, 0, 4);
        ev("t3_f7_close",   7, 0, 0, 0, 'h000, 0, 3);
        call(5);
        tick(5);
        call(3);
        call(7);
        drain(200);

        // 4: out-of-range calls, then the top floor
        ev("t4_err12",      7, 0, 0, 0, 'h000, 1, -1);
        ev("t4_err12_end",  7, 0, 0, 0, 'h000, 0, 1);
        call(12);
        drain(20);
        ev("t4_err10",      7, 0, 0, 0, 'h000, 1, -1);
        ev("t4_err10_end",  7, 0, 0, 0, 'h000, 0, 1);
        call(10);
        drain(20);
        ev("t4_call9",      7, 0, 0, 0, 'h200, 0, -1);
        ev("t4_go_up",      7, 1, 0, 0, 'h200, 0, 1);
        ev("t4_f8",         8, 1, 0, 0, 'h200, 0, 4);
        ev("t4_f9_door",    9, 0, 0, 1, 'h000, 0, 4);
        ev("t4_f9_close",   9, 0, 0, 0, 'h000, 0, 3);
        call(9);
        drain(100);

        // 5: same-floor call on the 2nd door cycle stretches the dwell
        ev("t5_call4",      9, 0, 0, 0, 'h010, 0, -1);
        ev("t5_go_down",    9, 0, 1, 0, 'h010, 0, 1);
        ev("t5_f8",         8, 0, 1, 0, 'h010, 0, 4);
        ev("t5_f7",         7, 0, 1, 0, 'h010, 0, 4);
        ev("t5_f6",         6, 0, 1, 0, 'h010, 0, 4);
        ev("t5_f5",         5, 0, 1, 0, 'h010, 0, 4);
        ev("t5_f4_door",    4, 0, 0, 1, 'h000, 0, 4);
        ev("t5_door_ext",   4, 0, 0, 0, 'h000, 0, 5);
        call(4);
        tick(22);
        call(4);
        drain(100);

        // 6: reset while moving down from floor 4
        ev("t6_call0",      4, 0, 0, 0, 'h001, 0, -1);
        ev("t6_go_down",    4, 0, 1, 0, 'h001, 0, 1);
        call(0);
        tick(2);
        check("t6_events_before_reset", expq.size(), 0);
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("t6_rst_floor", 32'(current_floor), 0);
        check("t6_rst_pending", 32'(pending), 0);
        check("t6_rst_down", 32'(moving_down), 0);
        check("t6_rst_ready", 32'(req_ready), 0);
        check("t6_rst_other", 32'({moving_up, door_open, req_err}), 0);
        tick(2);
        reset = 1'b1;
        tick(1);
        mon_en = 1'b1;
        check("t6_ready_again", 32'(req_ready), 1);
        tick(20);
        check("t6_still_floor0", 32'(current_floor), 0);
        check("t6_still_idle", 32'({moving_up, moving_down, door_open, pending}), 0);
        ev("t6_call2",      0, 0, 0, 0, 'h004, 0, -1);
        ev("t6_go_up",      0, 1, 0, 0, 'h004, 0, 1);
        ev("t6_f1",         1, 1, 0, 0, 'h004, 0, 4);
        ev("t6_f2_door",    2, 0, 0, 1, 'h000, 0, 4);
        ev("t6_f2_close",   2, 0, 0, 0, 'h000, 0, 3);
        call(2);
        drain(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
